cdc_afifo_gray_sync: RTL and testbench
======================================

# cdc_afifo_gray_sync

Receive-side companion to the async-FIFO gray pointer generator. It takes the remote domain's gray-coded pointer and runs it through a multi-flop synchronizer, giving the local pointer generator its synchronized `q2` gray value. It also decodes that value back to binary and derives registered occupancy, free-space and threshold flags for local flow control. One instance sits in each clock domain of an async FIFO: the write side watches the read pointer, and the read side watches the write pointer.

## Interface
Parameters:
- `abits`, 3: FIFO address width; pointers are `abits+1` bits; depth = 2^abits.
- `sync_stages`, 2: synchronizer flop count; legal range 2..4.
- `side`, 0: selects the local domain. 0 = write domain (local = wr, remote = rd). 1 = read domain (local = rd, remote = wr).
- `afull_lvl`, 2^abits-1: almost-full threshold on occupancy.
- `aempty_lvl`, 1: almost-empty threshold on occupancy.

Ports:
- `i_nrst`, in, 1: reset, asynchronous, active-low.
- `i_clk`, in, 1: local clock.
- `i_gray`, in, abits+1: remote gray pointer. It is asynchronous to `i_clk` and driven from a remote register.
- `i_local_bin`, in, abits+1: local binary pointer, synchronous to `i_clk`.
- `o_q2_gray`, out, abits+1: output of the last synchronizer flop; feeds the local pointer generator.
- `o_bin`, out, abits+1: registered binary decode of `o_q2_gray`.
- `o_level`, out, abits+1: registered occupancy, 0..2^abits.
- `o_free`, out, abits+1: registered 2^abits - occupancy.
- `o_almost_full`, out, 1: registered flag, set when level >= `afull_lvl`.
- `o_almost_empty`, out, 1: registered flag, set when level <= `aempty_lvl`.
- `o_err`, out, 1: sticky flag for an illegal occupancy.

## Operation
- **Synchronizer.** `sync_stages` flops in series, clocked by `i_clk`, reset to 0.
  - Stage 0 samples `i_gray`.
  - No logic between stages.
  - `o_q2_gray` is the last stage.
- **Decode (combinational from `o_q2_gray`).**
  - b[abits] = g[abits].
  - b[i] = b[i+1] ^ g[i], for i = abits-1 down to 0.
- **Occupancy.** Arithmetic is modulo 2^(abits+1), with no sign extension.
  - side 0: lvl = `i_local_bin` - b.
  - side 1: lvl = b - `i_local_bin`.
- **Output register (one stage).** Updated every cycle, no enable.
  - `o_bin` <= b.
  - `o_level` <= lvl.
  - `o_free` <= 2^abits - lvl.
  - `o_almost_full` <= (lvl >= `afull_lvl`).
  - `o_almost_empty` <= (lvl <= `aempty_lvl`).
- **Error detection.**
  - If lvl > 2^abits, `o_err` <= 1 and holds until reset.
  - A pointer that has overrun or a corrupt gray value produces this condition.
  - `o_level` and `o_free` still show the raw modulo values; no clamping.
- **Remote pointer jumps.** A remote clock faster than `i_clk` can move the pointer by several counts between samples. This is legal.
  - Multi-bit changes between consecutive `o_q2_gray` values are not flagged.
- **Flag conservatism.** Level is pessimistic for the local side.
  - The stale remote pointer can only under-report free space (write side) or under-report data (read side).
  - No correction logic is applied.
- **Reset.** All flops clear asynchronously. Reset values:
  - `o_q2_gray` = 0, `o_bin` = 0, `o_level` = 0.
  - `o_free` = 2^abits.
  - `o_almost_empty` = 1 (when `aempty_lvl` >= 0).
  - `o_almost_full` = 0, `o_err` = 0.
  - Reset mid-operation discards the synchronizer contents. Both domains are reset together by system convention.

## Timing
- A remote pointer change captured at local edge n appears on `o_q2_gray` after edge n+sync_stages-1.
- The same change appears on `o_bin`, `o_level` and the flags one edge later.
- A change of `i_local_bin` is reflected in `o_level` and the flags after the next edge (latency 1).
- Simultaneous local and remote movement:
  - The registered level uses the current `i_local_bin` and the current synchronized remote value.
  - The two updates are not coordinated.
- Wrap-around: pointer bit abits toggles every 2^abits counts. The modulo subtraction handles it with no special case.

## Structure
- Shared package `cdc_pkg` holds:
  - function `gray2bin(abits)` and function `bin2gray`;
  - constant `CDC_SYNC_STAGES_DEFAULT = 2`.
- One sub-module: `cdc_sync_bus #(width, stages)`, a plain flop chain with async reset. It is reusable for other single-bit and gray CDC paths.
- All remaining logic lives in this module's single register process.

## Test plan
- Reset release with `i_gray` = 0 and `i_local_bin` = 0 -> `o_level` = 0, `o_free` = 8 (abits = 3), `o_almost_empty` = 1, `o_err` = 0.
- side 1: step `i_gray` 0->1->3->2 (bin 0,1,2,3) while `i_local_bin` = 0 -> `o_bin` follows 0,1,2,3 with a sync_stages+1 cycle lag, and `o_level` = 3.
- side 0, full: `i_local_bin` = 8, remote gray = 0 -> `o_level` = 8, `o_free` = 0, `o_almost_full` = 1.
- Wrap-around, side 1: remote bin 15 (gray 8) and local 13 -> `o_level` = 2. Then remote bin 1 (gray 1) with local 15 -> `o_level` = 2, no `o_err`.
- Overrun: side 0, local bin 10 and remote bin 0 -> `o_level` = 10 and `o_err` = 1. `o_err` stays 1 after the pointers return to legal values, until `i_nrst` pulses low.
- Async reset asserted mid-stream -> all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared CDC helpers: gray/binary conversion and synchronizer defaults.
// Conversions operate on CDC_MAX_W-wide vectors; callers zero-extend narrower pointers.
package cdc_pkg;

   localparam int CDC_SYNC_STAGES_DEFAULT = 2;
   localparam int CDC_MAX_W               = 32;

   // Only the low w bits of g are significant; higher bits must be zero.
   function automatic logic [CDC_MAX_W-1:0] gray2bin(input logic [CDC_MAX_W-1:0] g,
                                                     input int                   w);
      logic [CDC_MAX_W-1:0] b;
      b        = '0;
      b[w-1]   = g[w-1];
      for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [CDC_MAX_W-1:0] bin2gray(input logic [CDC_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Plain multi-flop synchronizer chain with async active-low reset.
// Only safe for single bits or gray-coded buses that change one bit at a time.
module cdc_sync_bus #(
   parameter int width  = 1,
   parameter int stages = 2
) (
   input  logic             i_nrst,
   input  logic             i_clk,
   input  logic [width-1:0] i_d,
   output logic [width-1:0] o_q
);

   logic [stages-1:0][width-1:0] q;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         q <= '0;
      end else begin
         q[0] <= i_d;
         for (int s = 1; s < stages; s++) q[s] <= q[s-1];
      end
   end

   assign o_q = q[stages-1];

endmodule

// File: rtl/cdc_afifo_gray_sync.sv
// Receive side of an async-FIFO pointer crossing: synchronizes the remote gray
// pointer, decodes it, and registers occupancy / free space / threshold flags.
module cdc_afifo_gray_sync
   import cdc_pkg::*;
#(
   parameter int abits       = 3,
   parameter int sync_stages = CDC_SYNC_STAGES_DEFAULT,
   parameter int side        = 0,
   parameter int afull_lvl   = (1 << abits) - 1,
   parameter int aempty_lvl  = 1
) (
   input  logic             i_nrst,
   input  logic             i_clk,
   input  logic [abits:0]   i_gray,
   input  logic [abits:0]   i_local_bin,
   output logic [abits:0]   o_q2_gray,
   output logic [abits:0]   o_bin,
   output logic [abits:0]   o_level,
   output logic [abits:0]   o_free,
   output logic             o_almost_full,
   output logic             o_almost_empty,
   output logic             o_err
);

   localparam int            aw    = abits + 1;
   localparam logic [abits:0] depth = aw'(1 << abits);

   generate
      if (sync_stages < 2 || sync_stages > 4) begin : g_bad_stages
         $error("cdc_afifo_gray_sync: sync_stages must be 2..4");
      end
   endgenerate

   cdc_sync_bus #(
      .width  (aw),
      .stages (sync_stages)
   ) u_sync (
      .i_nrst (i_nrst),
      .i_clk  (i_clk),
      .i_d    (i_gray),
      .o_q    (o_q2_gray)
   );

   logic [CDC_MAX_W-1:0] b_wide;
   logic [abits:0]       b;
   logic [abits:0]       lvl;

   assign b_wide = gray2bin(CDC_MAX_W'(o_q2_gray), aw);
   assign b      = b_wide[abits:0];

   // Modulo subtraction absorbs wrap of the extra pointer bit.
   always_comb begin
      lvl = i_local_bin - b;
      if (side != 0) lvl = b - i_local_bin;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         o_bin          <= '0;
         o_level        <= '0;
         o_free         <= depth;
         o_almost_full  <= 1'b0;
         o_almost_empty <= (aempty_lvl >= 0);
         o_err          <= 1'b0;
      end else begin
         o_bin          <= b;
         o_level        <= lvl;
         o_free         <= depth - lvl;
         o_almost_full  <= (int'(lvl) >= afull_lvl);
         o_almost_empty <= (int'(lvl) <= aempty_lvl);
         // Sticky: an overrun or corrupt gray value is never self-healing.
         if (lvl > depth) o_err <= 1'b1;
      end
   end

   logic unused_ok;
   assign unused_ok = ^b_wide[CDC_MAX_W-1:aw];

endmodule

// File: tb/tb_cdc_afifo_gray_sync.sv
// Directed bench: a write-side (A) and a read-side (B) instance, abits=3, 2 sync stages.
module tb_cdc_afifo_gray_sync;

   logic       clk;
   logic       nrst;
   logic [3:0] a_gray, a_local, b_gray, b_local;
   logic [3:0] a_q2, a_bin, a_lvl, a_free;
   logic [3:0] b_q2, b_bin, b_lvl, b_free;
   logic       a_af, a_ae, a_err, b_af, b_ae, b_err;
   int         pass_cnt = 0;
   int         total    = 0;

   cdc_afifo_gray_sync #(.abits(3), .sync_stages(2), .side(0)) dut_a (
      .i_nrst(nrst), .i_clk(clk), .i_gray(a_gray), .i_local_bin(a_local),
      .o_q2_gray(a_q2), .o_bin(a_bin), .o_level(a_lvl), .o_free(a_free),
      .o_almost_full(a_af), .o_almost_empty(a_ae), .o_err(a_err));

   cdc_afifo_gray_sync #(.abits(3), .sync_stages(2), .side(1)) dut_b (
      .i_nrst(nrst), .i_clk(clk), .i_gray(b_gray), .i_local_bin(b_local),
      .o_q2_gray(b_q2), .o_bin(b_bin), .o_level(b_lvl), .o_free(b_free),
      .o_almost_full(b_af), .o_almost_empty(b_ae), .o_err(b_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; a_gray = 0; a_local = 0; b_gray = 0; b_local = 0;
      tick(2);
      total++; if (a_lvl !== 4'd0)  $display("FAIL reset_a_level got %0d want 0", a_lvl);  else pass_cnt++;
      total++; if (a_free !== 4'd8) $display("FAIL reset_a_free got %0d want 8", a_free);  else pass_cnt++;
      total++; if (a_ae !== 1'b1)   $display("FAIL reset_a_ae got %0b want 1", a_ae);      else pass_cnt++;
      total++; if (a_af !== 1'b0)   $display("FAIL reset_a_af got %0b want 0", a_af);      else pass_cnt++;
      total++; if (a_err !== 1'b0)  $display("FAIL reset_a_err got %0b want 0", a_err);    else pass_cnt++;
      nrst = 1'b1;
      tick(4);
      total++; if (b_lvl !== 4'd0)  $display("FAIL rel_b_level got %0d want 0", b_lvl);   else pass_cnt++;
      total++; if (b_free !== 4'd8) $display("FAIL rel_b_free got %0d want 8", b_free);   else pass_cnt++;
      total++; if (b_ae !== 1'b1)   $display("FAIL rel_b_ae got %0b want 1", b_ae);       else pass_cnt++;
      total++; if (b_err !== 1'b0)  $display("FAIL rel_b_err got %0b want 0", b_err);     else pass_cnt++;
   endtask

   task automatic test_sync_latency();
      b_local = 0;
      b_gray = 4'd1;
      tick(1);
      total++; if (b_q2 !== 4'd0)   $display("FAIL lat_q2_early got %0d want 0", b_q2);   else pass_cnt++;
      tick(1);
      total++; if (b_q2 !== 4'd1)   $display("FAIL lat_q2 got %0d want 1", b_q2);         else pass_cnt++;
      total++; if (b_bin !== 4'd0)  $display("FAIL lat_bin_early got %0d want 0", b_bin); else pass_cnt++;
      tick(1);
      total++; if (b_bin !== 4'd1)  $display("FAIL lat_bin1 got %0d want 1", b_bin);      else pass_cnt++;
      total++; if (b_lvl !== 4'd1)  $display("FAIL lat_lvl1 got %0d want 1", b_lvl);      else pass_cnt++;
      b_gray = 4'd3;
      tick(3);
      total++; if (b_bin !== 4'd2)  $display("FAIL step_bin2 got %0d want 2", b_bin);     else pass_cnt++;
      total++; if (b_ae !== 1'b0)   $display("FAIL step_ae2 got %0b want 0", b_ae);       else pass_cnt++;
      b_gray = 4'd2;
      tick(3);
      total++; if (b_bin !== 4'd3)  $display("FAIL step_bin3 got %0d want 3", b_bin);     else pass_cnt++;
      total++; if (b_lvl !== 4'd3)  $display("FAIL step_lvl3 got %0d want 3", b_lvl);     else pass_cnt++;
      total++; if (b_free !== 4'd5) $display("FAIL step_free3 got %0d want 5", b_free);   else pass_cnt++;
   endtask

   task automatic test_local_latency();
      b_local = 4'd1;
      tick(1);
      total++; if (b_lvl !== 4'd2)  $display("FAIL local_lat got %0d want 2", b_lvl);     else pass_cnt++;
   endtask

   task automatic test_full_thresholds();
      a_gray = 0; a_local = 4'd8;
      tick(3);
      total++; if (a_lvl !== 4'd8)  $display("FAIL full_level got %0d want 8", a_lvl);    else pass_cnt++;
      total++; if (a_free !== 4'd0) $display("FAIL full_free got %0d want 0", a_free);    else pass_cnt++;
      total++; if (a_af !== 1'b1)   $display("FAIL full_af got %0b want 1", a_af);        else pass_cnt++;
      total++; if (a_err !== 1'b0)  $display("FAIL full_err got %0b want 0", a_err);      else pass_cnt++;
      a_local = 4'd7; tick(1);
      total++; if (a_af !== 1'b1)   $display("FAIL af_at7 got %0b want 1", a_af);         else pass_cnt++;
      a_local = 4'd6; tick(1);
      total++; if (a_af !== 1'b0)   $display("FAIL af_at6 got %0b want 0", a_af);         else pass_cnt++;
      a_local = 4'd1; tick(1);
      total++; if (a_ae !== 1'b1)   $display("FAIL ae_at1 got %0b want 1", a_ae);         else pass_cnt++;
      a_local = 4'd2; tick(1);
      total++; if (a_ae !== 1'b0)   $display("FAIL ae_at2 got %0b want 0", a_ae);         else pass_cnt++;
   endtask

   task automatic test_wrap();
      b_gray = 4'd8; b_local = 4'd13;
      tick(3);
      total++; if (b_bin !== 4'd15) $display("FAIL wrap_bin15 got %0d want 15", b_bin);   else pass_cnt++;
      total++; if (b_lvl !== 4'd2)  $display("FAIL wrap_lvl_a got %0d want 2", b_lvl);    else pass_cnt++;
      b_gray = 4'd1; b_local = 4'd15;
      tick(3);
      total++; if (b_lvl !== 4'd2)  $display("FAIL wrap_lvl_b got %0d want 2", b_lvl);    else pass_cnt++;
      total++; if (b_err !== 1'b0)  $display("FAIL wrap_err got %0b want 0", b_err);      else pass_cnt++;
   endtask

   task automatic test_overrun_and_async_reset();
      a_gray = 0; a_local = 4'd10;
      tick(3);
      total++; if (a_lvl !== 4'd10)  $display("FAIL ovr_level got %0d want 10", a_lvl);   else pass_cnt++;
      total++; if (a_free !== 4'd14) $display("FAIL ovr_free got %0d want 14", a_free);   else pass_cnt++;
      total++; if (a_err !== 1'b1)   $display("FAIL ovr_err got %0b want 1", a_err);      else pass_cnt++;
      a_local = 4'd3;
      tick(3);
      total++; if (a_lvl !== 4'd3)   $display("FAIL ovr_back_lvl got %0d want 3", a_lvl); else pass_cnt++;
      total++; if (a_err !== 1'b1)   $display("FAIL ovr_sticky got %0b want 1", a_err);   else pass_cnt++;
      // Mid-stream reset, checked before any further clock edge.
      #1 nrst = 1'b0;
      #1;
      total++; if (a_err !== 1'b0)   $display("FAIL ares_err got %0b want 0", a_err);     else pass_cnt++;
      total++; if (a_lvl !== 4'd0)   $display("FAIL ares_lvl got %0d want 0", a_lvl);     else pass_cnt++;
      total++; if (b_q2 !== 4'd0)    $display("FAIL ares_q2 got %0d want 0", b_q2);       else pass_cnt++;
      total++; if (b_bin !== 4'd0)   $display("FAIL ares_bin got %0d want 0", b_bin);     else pass_cnt++;
      total++; if (b_free !== 4'd8)  $display("FAIL ares_free got %0d want 8", b_free);   else pass_cnt++;
      total++; if (b_ae !== 1'b1)    $display("FAIL ares_ae got %0b want 1", b_ae);       else pass_cnt++;
      nrst = 1'b1;
      tick(1);
   endtask

   initial begin
      test_reset();
      test_sync_latency();
      test_local_latency();
      test_full_thresholds();
      test_wrap();
      test_overrun_and_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
